// File: rtl/ether_rx.sv
// Purpose : RMII receive framer. Hunts preamble + SFD, strips them, and streams frame dibits out.
//           Also reports end-of-frame, whole-byte count and alignment error.
// Latency : 1 cycle from accepted dibit to axiov/axiod. With ETHER_RX_FCS_STRIP_EN defined,
//           the lag is 16 accepted dibits + 1 cycle.
// Backpr. : none. The PHY cannot be stalled, so downstream must take every axiov beat.
//
// Ports:
//   clk, rstn         50 MHz reference clock; asynchronous active-low reset
//   crsdv, rxd[1:0]   RMII CRS_DV / RXD from the PHY
//   axiov, axiod[1:0] frame dibit valid / data, LSB pair of each byte first
//   frame_done        one-cycle pulse at the end of every locked frame
//   frame_err         pulse with frame_done when the frame is not a whole number of bytes
//   byte_count[15:0]  whole bytes of the last frame, held until the next frame_done
//
// Optional feature macro: ETHER_RX_FCS_STRIP_EN. It holds back the last 16 dibits (the FCS)
// and excludes them from byte_count.
module ether_rx #(
    parameter int MIN_PREAMBLE = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        crsdv,
    input  logic [1:0]  rxd,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] byte_count
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DONE,
        WAIT_IDLE
    } state_t;

    localparam logic [7:0]  MIN_PRE = 8'(MIN_PREAMBLE);
    localparam logic [7:0]  PRE_MAX = 8'hFF;
    localparam logic [17:0] DIB_MAX = 18'h3FFFF;

    state_t      state;
    logic [7:0]  pre_cnt;
    logic [17:0] dib_cnt;
    logic        prev_low;   // crsdv was low at the previous sample
    logic        eoc;        // second consecutive low sample: carrier has ended

`ifdef ETHER_RX_FCS_STRIP_EN
    logic [31:0] dly;        // 16-dibit delay line; newest dibit in the low bits
`endif

    assign eoc = !crsdv && prev_low;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            pre_cnt    <= 8'd0;
            dib_cnt    <= 18'd0;
            prev_low   <= 1'b0;
            axiov      <= 1'b0;
            axiod      <= 2'b00;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            byte_count <= 16'd0;
`ifdef ETHER_RX_FCS_STRIP_EN
            dly        <= 32'd0;
`endif
        end else begin
            // Pulses and valid default low. They are reasserted below only in their cycle.
            axiov      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            prev_low   <= !crsdv;

            case (state)
                IDLE: begin
                    if (crsdv) begin
                        if (rxd == 2'b01) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 8'd1;
                        end else begin
                            // Joined mid-frame: sit out the rest of this carrier.
                            state <= WAIT_IDLE;
                        end
                    end
                end

                PREAMBLE: begin
                    if (eoc) begin
                        state   <= IDLE;
                        pre_cnt <= 8'd0;
                    end else if (crsdv) begin
                        case (rxd)
                            2'b01: begin
                                if (pre_cnt != PRE_MAX) begin
                                    pre_cnt <= pre_cnt + 8'd1;
                                end
                            end
                            2'b11: begin
                                if (pre_cnt >= MIN_PRE) begin
                                    state   <= DATA;
                                    dib_cnt <= 18'd0;
                                end else begin
                                    state <= WAIT_IDLE;
                                end
                            end
                            default: state <= WAIT_IDLE;
                        endcase
                    end
                end

                DATA: begin
                    if (eoc) begin
                        state <= DONE;
                    end else if (crsdv) begin
                        if (dib_cnt != DIB_MAX) begin
                            dib_cnt <= dib_cnt + 18'd1;
                        end
`ifdef ETHER_RX_FCS_STRIP_EN
                        // A dibit leaves only once 16 newer ones sit behind it.
                        // The trailing 16 (the FCS) are therefore never emitted.
                        dly <= {dly[29:0], rxd};
                        if (dib_cnt >= 18'd16) begin
                            axiov <= 1'b1;
                            axiod <= dly[31:30];
                        end
`else
                        axiov <= 1'b1;
                        axiod <= rxd;
`endif
                    end
                end

                DONE: begin
                    frame_done <= 1'b1;
                    frame_err  <= |dib_cnt[1:0];
`ifdef ETHER_RX_FCS_STRIP_EN
                    byte_count <= (dib_cnt[17:2] >= 16'd4) ? (dib_cnt[17:2] - 16'd4) : 16'd0;
`else
                    // The 18-bit saturating counter shifted by 2 cannot exceed 16'hFFFF.
                    byte_count <= dib_cnt[17:2];
`endif
                    pre_cnt <= 8'd0;
                    dib_cnt <= 18'd0;
                    state   <= IDLE;
                end

                WAIT_IDLE: begin
                    if (eoc) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
